// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types, constants and bus-slicing helper for the register file.
package regfile_pkg;
  typedef enum logic {CLEAR, RUN} state_e;
  localparam int ZERO_REG = 0;
  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction
endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: one combinational read port with zero-register, write bypass and busy lookup.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              run,
  input  logic [ADDR_W-1:0] src,
  input  logic              wen,
  input  logic [ADDR_W-1:0] wtarget,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [WIDTH-1:0]  mem_data,
  input  logic              busy_bit,
  output logic [WIDTH-1:0]  data,
  output logic              busy
);
  logic zero, bypass;
  always_comb begin
    zero   = !run || src == ADDR_W'(ZERO_REG);
    bypass = wen && wtarget == src;
    data   = zero ? '0 : bypass ? wdata : mem_data;
    busy   = !zero && !bypass && busy_bit;
  end
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: multi-port register file with write bypass, busy scoreboard and post-reset clear sweep.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_READ = 2,
  parameter int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                       Clock,
  input  logic                       ResetN,
  input  logic [WIDTH-1:0]           WriteData,
  input  logic [ADDR_W-1:0]          WriteTarget,
  input  logic                       WriteEnable,
  input  logic                       ReserveEnable,
  input  logic [ADDR_W-1:0]          ReserveTarget,
  input  logic                       Flush,
  input  logic [NUM_READ*ADDR_W-1:0] ReadSource,
  output logic [NUM_READ*WIDTH-1:0]  ReadPort,
  output logic [NUM_READ-1:0]        ReadBusy,
  output logic                       Ready
);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [WIDTH-1:0] mem_wd;
  logic run, wr_ok, rsv_ok;
  // Busy update order: write releases, reserve re-claims, flush overrides everything.
  always_comb begin
    run     = state_q == RUN;
    wr_ok   = run && WriteEnable && WriteTarget != ADDR_W'(ZERO_REG);
    rsv_ok  = run && ReserveEnable && ReserveTarget != ADDR_W'(ZERO_REG);
    state_d = (!run && cnt_q == ADDR_W'(DEPTH - 1)) ? RUN : state_q;
    cnt_d   = run ? cnt_q : cnt_q + ADDR_W'(1);
    mem_we  = !run || wr_ok;
    mem_wa  = run ? WriteTarget : cnt_q;
    mem_wd  = run ? WriteData : '0;
    busy_d  = busy_q;
    if (wr_ok) busy_d[WriteTarget] = 1'b0;
    if (rsv_ok) busy_d[ReserveTarget] = 1'b1;
    if (run && Flush) busy_d = '0;
    busy_d[ZERO_REG] = 1'b0;
  end
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end
  always_ff @(posedge Clock) begin
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  end
  assign Ready = run;
  for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
    logic [ADDR_W-1:0] src;
    assign src = ReadSource[slice_lo(i, ADDR_W) +: ADDR_W];
    regfile_read_port #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_rd (
      .run      (run),
      .src      (src),
      .wen      (WriteEnable),
      .wtarget  (WriteTarget),
      .wdata    (WriteData),
      .mem_data (mem_q[src]),
      .busy_bit (busy_q[src]),
      .data     (ReadPort[slice_lo(i, WIDTH) +: WIDTH]),
      .busy     (ReadBusy[i])
    );
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed stimulus with a behavioural model compared every cycle.
module tb_regfile_scoreboard;
  localparam int W = 32, D = 32, N = 2, A = 5;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [W-1:0] wd;
  logic [A-1:0] wt, rt;
  logic we, re, fl;
  logic [N*A-1:0] rs;
  logic [N*W-1:0] rp;
  logic [N-1:0] rb;
  logic rdy;
  logic [63:0] wd6;
  logic [5:0] wt6;
  logic we6;
  logic [17:0] rs6;
  logic [191:0] rp6;
  logic [2:0] rb6;
  logic rdy6;
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  regfile_scoreboard dut (
    .Clock(clk), .ResetN(rst_n), .WriteData(wd), .WriteTarget(wt), .WriteEnable(we),
    .ReserveEnable(re), .ReserveTarget(rt), .Flush(fl), .ReadSource(rs),
    .ReadPort(rp), .ReadBusy(rb), .Ready(rdy)
  );
  regfile_scoreboard #(.WIDTH(64), .DEPTH(64), .NUM_READ(3)) dut64 (
    .Clock(clk), .ResetN(rst_n), .WriteData(wd6), .WriteTarget(wt6), .WriteEnable(we6),
    .ReserveEnable(1'b0), .ReserveTarget(6'd0), .Flush(1'b0), .ReadSource(rs6),
    .ReadPort(rp6), .ReadBusy(rb6), .Ready(rdy6)
  );
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Model: memory is all-zero once D edges have elapsed since reset; only then do writes, reserves and flushes count.
  logic [W-1:0] m_mem [D];
  logic m_busy [D];
  int m_edges;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_edges = 0;
      for (int k = 0; k < D; k++) m_busy[k] = 1'b0;
    end else if (m_edges < D) begin
      m_edges++;
      if (m_edges == D)
        for (int k = 0; k < D; k++) begin
          m_mem[k] = '0;
          m_busy[k] = 1'b0;
        end
    end else begin
      if (we && wt != 0) begin
        m_mem[wt] = wd;
        m_busy[wt] = 1'b0;
      end
      if (fl) for (int k = 0; k < D; k++) m_busy[k] = 1'b0;
      else if (re && rt != 0) m_busy[rt] = 1'b1;
    end
  end
  always @(negedge clk) begin
    logic [W-1:0] ed;
    logic eb;
    int s;
    check("ready", {63'd0, rdy}, {63'd0, m_edges >= D});
    for (int i = 0; i < N; i++) begin
      s = int'(rs[i*A +: A]);
      if (m_edges < D || s == 0) begin
        ed = '0;
        eb = 1'b0;
      end else if (we && int'(wt) == s) begin
        ed = wd;
        eb = 1'b0;
      end else begin
        ed = m_mem[s];
        eb = m_busy[s];
      end
      check($sformatf("port%0d_data", i), {32'd0, rp[i*W +: W]}, {32'd0, ed});
      check($sformatf("port%0d_busy", i), {63'd0, rb[i]}, {63'd0, eb});
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic count_ready(output int n);
    n = 0;
    while (!rdy && n < 40) begin
      step();
      n++;
    end
  endtask
  initial begin
    int n;
    we = 0; re = 0; fl = 0; wd = '0; wt = '0; rt = '0; rs = '0;
    we6 = 0; wt6 = '0; wd6 = '0; rs6 = '0;
    step(); step();
    rst_n = 1'b1;
    rs = {5'd0, 5'd5};
    #1 check("ready_low_after_reset", {63'd0, rdy}, 64'd0);
    check("r5_before_ready", {32'd0, rp[31:0]}, 64'd0);
    count_ready(n);
    check("ready_edges", 64'(n), 64'd32);
    #1 check("r5_after_ready", {32'd0, rp[31:0]}, 64'd0);
    check("r5_busy", {63'd0, rb[0]}, 64'd0);
    n = 0;
    while (!rdy6 && n < 40) begin
      step();
      n++;
    end
    check("p64_ready", {63'd0, rdy6}, 64'd1);
    wd6 = 64'hDEADBEEF_CAFEF00D; wt6 = 6'd7; we6 = 1; rs6 = {6'd7, 6'd0, 6'd0};
    #1 check("p64_bypass_port2", rp6[191:128], 64'hDEADBEEF_CAFEF00D);
    check("p64_port0_r0", rp6[63:0], 64'd0);
    check("p64_busy2", {63'd0, rb6[2]}, 64'd0);
    step();
    we6 = 0;
    #1 check("p64_storage_port2", rp6[191:128], 64'hDEADBEEF_CAFEF00D);
    wd = 32'hDEADBEEF; wt = 5'd7; we = 1; rs = {5'd0, 5'd7};
    #1 check("r7_bypass", {32'd0, rp[31:0]}, 64'hDEADBEEF);
    step();
    we = 0;
    #1 check("r7_storage", {32'd0, rp[31:0]}, 64'hDEADBEEF);
    re = 1; rt = 5'd3;
    step();
    re = 0; rs = {5'd3, 5'd3};
    #1 check("r3_busy_both", {62'd0, rb}, 64'd3);
    we = 1; wt = 5'd3; wd = 32'h12345678;
    #1 check("r3_write_busy", {62'd0, rb}, 64'd0);
    check("r3_bypass_p0", {32'd0, rp[31:0]}, 64'h12345678);
    check("r3_bypass_p1", {32'd0, rp[63:32]}, 64'h12345678);
    step();
    we = 0;
    #1 check("r3_released", {62'd0, rb}, 64'd0);
    we = 1; wt = 5'd9; wd = 32'h55; re = 1; rt = 5'd9;
    step();
    we = 0; re = 0; rs = {5'd0, 5'd9};
    #1 check("r9_data", {32'd0, rp[31:0]}, 64'h55);
    check("r9_busy", {63'd0, rb[0]}, 64'd1);
    re = 1; rt = 5'd4;
    step();
    rt = 5'd6;
    step();
    rt = 5'd8; fl = 1;
    step();
    re = 0; fl = 0; rs = {5'd6, 5'd4};
    #1 check("flush_r4_r6", {62'd0, rb}, 64'd0);
    rs = {5'd8, 5'd9};
    #1 check("flush_r8_r9", {62'd0, rb}, 64'd0);
    we = 1; wt = 5'd0; wd = 32'hFFFFFFFF; re = 1; rt = 5'd0; rs = {5'd0, 5'd0};
    #1 check("r0_write_p0", {32'd0, rp[31:0]}, 64'd0);
    check("r0_write_p1", {32'd0, rp[63:32]}, 64'd0);
    step();
    we = 0; re = 0;
    #1 check("r0_after", {32'd0, rp[31:0]}, 64'd0);
    check("r0_busy", {62'd0, rb}, 64'd0);
    we = 1; wt = 5'd2; wd = 32'hA5;
    step();
    we = 0; rs = {5'd0, 5'd2};
    #1 check("r2_written", {32'd0, rp[31:0]}, 64'hA5);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1 check("ready_low_restart", {63'd0, rdy}, 64'd0);
    count_ready(n);
    check("restart_ready_edges", 64'(n), 64'd32);
    rs = {5'd9, 5'd2};
    #1 check("r2_cleared", {32'd0, rp[31:0]}, 64'd0);
    check("r9_cleared", {32'd0, rp[63:32]}, 64'd0);
    check("busy_cleared", {62'd0, rb}, 64'd0);
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
